// File: rtl/falcon_seq_ctrl.sv
// Host/core sequencer for tt_um_falcon: loads operand bytes, starts the core, waits with timeout,
// then hands result bytes back over the uio pins with a strobe/ack handshake.
module falcon_seq_ctrl #(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] host_data,
    input  logic       host_stb,
    input  logic       host_ack,
    output logic       core_wr_en,
    output logic [3:0] core_addr,
    output logic [7:0] core_wdata,
    output logic       core_start,
    input  logic       core_done,
    input  logic [7:0] core_rdata,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic       busy,
    output logic       err,
    output logic [7:0] uio_oe_ctrl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_DRAIN,
        S_ABORT
    } state_t;

    localparam logic [4:0] IN_LAST  = 5'(IN_BYTES - 1);
    localparam logic [4:0] OUT_LAST = 5'(OUT_BYTES - 1);
    localparam logic [9:0] TMO      = 10'(TIMEOUT);

    state_t     state;
    logic [4:0] cnt;
    logic [9:0] tmr;

    logic stb_p0, stb_p1, stb_p2;
    logic ack_p0, ack_p1, ack_p2;
    logic stb_ev, ack_ev;

    // Synchronizer: p0/p1 are the 2-FF stage, p2 holds the previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_p0 <= 1'b0;
            stb_p1 <= 1'b0;
            stb_p2 <= 1'b0;
            ack_p0 <= 1'b0;
            ack_p1 <= 1'b0;
            ack_p2 <= 1'b0;
        end else begin
            stb_p0 <= host_stb;
            stb_p1 <= stb_p0;
            stb_p2 <= stb_p1;
            ack_p0 <= host_ack;
            ack_p1 <= ack_p0;
            ack_p2 <= ack_p1;
        end
    end

    assign stb_ev = stb_p1 & ~stb_p2;
    assign ack_ev = ack_p1 & ~ack_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            tmr         <= 10'd0;
            core_wr_en  <= 1'b0;
            core_addr   <= 4'd0;
            core_wdata  <= 8'd0;
            core_start  <= 1'b0;
            res_data    <= 8'd0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            uio_oe_ctrl <= 8'h00;
        end else begin
            core_wr_en <= 1'b0;
            core_start <= 1'b0;
            // With ena low everything except the strobe pulses is frozen and events are lost
            if (ena) begin
                case (state)
                    S_IDLE: begin
                        if (stb_ev) begin
                            core_wr_en <= 1'b1;
                            core_addr  <= 4'd0;
                            core_wdata <= host_data;
                            cnt        <= 5'd1;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (stb_ev) begin
                            core_wr_en <= 1'b1;
                            core_addr  <= cnt[3:0];
                            core_wdata <= host_data;
                            if (cnt == IN_LAST) begin
                                cnt   <= 5'd0;
                                state <= S_START;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    S_START: begin
                        core_start <= 1'b1;
                        core_addr  <= 4'd0;
                        tmr        <= 10'd0;
                        state      <= S_BUSY;
                    end
                    S_BUSY: begin
                        tmr <= tmr + 10'd1;
                        if (core_done) begin
                            cnt         <= 5'd0;
                            core_addr   <= 4'd0;
                            res_valid   <= 1'b0;
                            uio_oe_ctrl <= 8'hFC;
                            state       <= S_DRAIN;
                        end else if (tmr == TMO) begin
                            err         <= 1'b1;
                            uio_oe_ctrl <= 8'h00;
                            state       <= S_ABORT;
                        end
                    end
                    S_DRAIN: begin
                        // A cleared res_valid means core_addr already points at the next byte
                        if (!res_valid) begin
                            res_data  <= core_rdata;
                            res_valid <= 1'b1;
                        end else if (ack_ev) begin
                            res_valid <= 1'b0;
                            if (cnt == OUT_LAST) begin
                                cnt         <= 5'd0;
                                core_addr   <= 4'd0;
                                uio_oe_ctrl <= 8'h00;
                                busy        <= 1'b0;
                                state       <= S_IDLE;
                            end else begin
                                cnt       <= cnt + 5'd1;
                                core_addr <= cnt[3:0] + 4'd1;
                            end
                        end
                    end
                    S_ABORT: begin
                        uio_oe_ctrl <= 8'h00;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_falcon_seq_ctrl.sv
// Directed bench for falcon_seq_ctrl: a transaction-level model predicts operand writes, start
// pulses and result bytes, and a per-cycle monitor compares the DUT against it.
module tb_falcon_seq_ctrl;

    localparam int IN_BYTES  = 8;
    localparam int OUT_BYTES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] host_data = 8'h00;
    logic       host_stb = 1'b0;
    logic       host_ack = 1'b0;
    logic       core_done = 1'b0;
    logic [7:0] core_rdata;
    logic       core_wr_en, core_start, res_valid, busy, err;
    logic [3:0] core_addr;
    logic [7:0] core_wdata, res_data, uio_oe_ctrl;

    falcon_seq_ctrl #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .TIMEOUT(1023)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .host_data(host_data), .host_stb(host_stb), .host_ack(host_ack),
        .core_wr_en(core_wr_en), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_start(core_start), .core_done(core_done), .core_rdata(core_rdata),
        .res_data(res_data), .res_valid(res_valid), .busy(busy), .err(err),
        .uio_oe_ctrl(uio_oe_ctrl)
    );

    always #5 clk = ~clk;

    // Core result memory: byte at index i is A0+i
    assign core_rdata = 8'hA0 + {4'h0, core_addr};

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = -1;
    int last_wr_cyc = -1;
    int err_cyc = -1;
    int starts_seen = 0;
    int exp_starts = 0;
    int m_cnt = 0;
    bit m_accept = 1'b1;
    logic [11:0] exp_wr[$];
    logic [7:0]  exp_res[$];
    logic [11:0] e_wr;
    logic [7:0]  e_res;
    logic prev_rv = 1'b0;
    logic prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Per-cycle monitor against the model's expectation queues
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (core_wr_en) begin
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("write", 32'({core_addr, core_wdata}), 32'(e_wr));
                end
            end
            if (core_start) begin
                starts_seen++;
                start_cyc = cyc;
            end
            if (err && !prev_err) err_cyc = cyc;
            if (res_valid && !prev_rv) begin
                if (exp_res.size() == 0) begin
                    flag("unexpected_result");
                end else begin
                    e_res = exp_res.pop_front();
                    check("result", 32'(res_data), 32'(e_res));
                end
                check("result_oe", 32'(uio_oe_ctrl), 32'h0000_00FC);
            end
        end
        prev_rv  = rst_n ? res_valid : 1'b0;
        prev_err = rst_n ? err : 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_stb(input logic [7:0] d);
        host_data = d;
        host_stb  = 1'b1;
        if (ena && m_accept) begin
            exp_wr.push_back({4'(m_cnt), d});
            m_cnt++;
            if (m_cnt == IN_BYTES) begin
                m_cnt    = 0;
                m_accept = 1'b0;
                exp_starts++;
            end
        end
        step(2);
        host_stb = 1'b0;
        step(3);
    endtask

    task automatic ack_pulse(input bit glitch);
        host_ack = 1'b1;
        if (glitch) begin
            #3 host_ack = 1'b0;
            #1 host_ack = 1'b1;
        end
        step(3);
        host_ack = 1'b0;
        step(4);
    endtask

    task automatic done_pulse();
        for (int i = 0; i < OUT_BYTES; i++) exp_res.push_back(8'hA0 + 8'(i));
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (starts_seen < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (starts_seen < target) flag("start_timeout");
        step(1);
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) flag("res_valid_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        // Reset state
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_oe", 32'(uio_oe_ctrl), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_wr_en", 32'(core_wr_en), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_addr", 32'(core_addr), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Command 1: load 0x11..0x88 with a stray ack during LOAD, done after 20 cycles
        c0 = cyc;
        send_stb(8'h11);
        check("stb_latency", 32'(last_wr_cyc - c0), 32'd4);
        check("busy_after_first", 32'(busy), 32'd1);
        send_stb(8'h22);
        ack_pulse(1'b0);
        for (int i = 3; i <= 8; i++) send_stb(8'(i * 16 + i));
        wait_start(1);
        check("start_after_last_write", 32'(start_cyc - last_wr_cyc), 32'd1);
        check("busy_in_busy", 32'(busy), 32'd1);
        send_stb(8'hEE);
        send_stb(8'hDD);
        step(9);
        done_pulse();
        for (int i = 0; i < OUT_BYTES; i++) begin
            wait_rv();
            step(1);
            check("drain_byte", 32'(res_data), 32'(8'hA0 + 8'(i)));
            check("drain_oe", 32'(uio_oe_ctrl), 32'h0000_00FC);
            step(6);
            check("drain_hold_valid", 32'(res_valid), 32'd1);
            check("drain_hold_data", 32'(res_data), 32'(8'hA0 + 8'(i)));
            ack_pulse(i == 1);
        end
        m_accept = 1'b1;
        step(2);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_oe", 32'(uio_oe_ctrl), 32'd0);
        check("idle_res_valid", 32'(res_valid), 32'd0);
        check("results_consumed", 32'(exp_res.size()), 32'd0);

        // Command 2: no done, must abort 1024 cycles after start
        for (int i = 0; i < IN_BYTES; i++) send_stb(8'h40 + 8'(i));
        wait_start(2);
        send_stb(8'h99);
        begin
            int n = 0;
            while (err_cyc < 0 && n < 1200) begin
                @(negedge clk);
                n++;
            end
            if (err_cyc < 0) flag("abort_timeout");
        end
        check("abort_time", 32'(err_cyc - start_cyc), 32'd1024);
        step(3);
        check("abort_err", 32'(err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(uio_oe_ctrl), 32'd0);
        m_accept = 1'b1;

        // Command 3: next stb clears err; ena low during LOAD drops strobes
        send_stb(8'h01);
        check("err_cleared", 32'(err), 32'd0);
        send_stb(8'h02);
        send_stb(8'h03);
        ena = 1'b0;
        for (int i = 0; i < 8; i++) send_stb(8'hF0 + 8'(i));
        step(10);
        ena = 1'b1;
        step(1);
        for (int i = 4; i <= 8; i++) send_stb(8'(i));
        wait_start(3);
        check("start_count", 32'(starts_seen), 32'(exp_starts));
        step(5);
        done_pulse();
        wait_rv();
        step(1);
        check("cmd3_first_byte", 32'(res_data), 32'h0000_00A0);
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", 32'(uio_oe_ctrl), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(res_valid), 32'd0);
        exp_res.delete();
        m_accept = 1'b1;
        m_cnt = 0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("writes_consumed", 32'(exp_wr.size()), 32'd0);
        check("post_rst_oe", 32'(uio_oe_ctrl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
